// File: rtl/minterm_scanner_if.sv
// Bundle of signals between minterm_scanner and the function block / controller.
// The scanner uses the slave modport; whoever starts scans and supplies
// the function block's led output uses the master modport.
interface minterm_scanner_if;
    logic        start;
    logic        led_in;
    logic [3:0]  stim;
    logic [15:0] truth;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;

    modport master (
        output start,
        output led_in,
        input  stim,
        input  truth,
        input  busy,
        input  done,
        input  pass,
        input  mismatch_count,
        input  first_fail
    );

    modport slave (
        input  start,
        input  led_in,
        output stim,
        output truth,
        output busy,
        output done,
        output pass,
        output mismatch_count,
        output first_fail
    );
endinterface

// File: rtl/minterm_scanner.sv
// minterm_scanner: walks all 16 input patterns of a 4-input function block,
// captures its led output into a truth table and compares against EXPECTED.
// Optional build macro MINTERM_SCANNER_LOOP_EN: after the first start the
// scanner free-runs, pulsing done for one cycle at the end of every scan.
module minterm_scanner #(
    parameter logic [15:0] EXPECTED      = 16'h545E,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    minterm_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

`ifdef MINTERM_SCANNER_LOOP_EN
    // In free-run mode stim is already 0 during the DONE cycle, so that cycle
    // counts as the first settle cycle of the next pass; this keeps the scan
    // period at exactly 16*(SETTLE_CYCLES+1) edges.
    localparam logic [7:0] LOOP_RELOAD = (SETTLE_CYCLES > 1) ? 8'(SETTLE_CYCLES - 2) : 8'd0;
    localparam state_t     LOOP_ENTRY  = (SETTLE_CYCLES > 1) ? SETTLE : SAMPLE;
`endif

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  stim_q, stim_d;
    logic [15:0] truth_q, truth_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  mismatch_q, mismatch_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        launch;

    assign bus.stim           = stim_q;
    assign bus.truth          = truth_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.first_fail     = first_fail_q;

    // State and result registers; reset aborts any scan and clears all results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= 8'd0;
            stim_q       <= 4'd0;
            truth_q      <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= 5'd0;
            first_fail_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            truth_q      <= truth_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Next-state logic: settle, sample one pattern, advance or finish.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        stim_d       = stim_q;
        truth_d      = truth_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        launch       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    launch = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                truth_d[idx_q] = bus.led_in;
                if (bus.led_in != EXPECTED[idx_q]) begin
                    if (mismatch_q == 5'd0) begin
                        first_fail_d = idx_q;
                    end
                    mismatch_d = mismatch_q + 5'd1;
                end
                if (idx_q != 4'd15) begin
                    idx_d   = idx_q + 4'd1;
                    stim_d  = idx_q + 4'd1;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    stim_d  = 4'd0;
                    pass_d  = (mismatch_d == 5'd0);
                end
            end
            DONE: begin
`ifdef MINTERM_SCANNER_LOOP_EN
                launch = 1'b1;
`else
                if (bus.start) begin
                    launch = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            idx_d        = 4'd0;
            stim_d       = 4'd0;
            truth_d      = 16'd0;
            mismatch_d   = 5'd0;
            first_fail_d = 4'd0;
            pass_d       = 1'b0;
            done_d       = 1'b0;
            busy_d       = 1'b1;
            state_d      = SETTLE;
            cnt_d        = RELOAD;
`ifdef MINTERM_SCANNER_LOOP_EN
            if (state_q == DONE) begin
                state_d = LOOP_ENTRY;
                cnt_d   = LOOP_RELOAD;
            end
`endif
        end
    end

endmodule
